// File: rtl/id_stage_hazard.sv
// id_stage_hazard: MIPS decode stage. Register file with write-through,
// control decode, load-use and branch hazard detection, branch/jump
// resolution with MEM-stage forwarding, and the ID/EX pipeline register.
module id_stage_hazard #(
   parameter int NB_DATA  = 32,
   parameter int NB_ADDR  = 5,
   parameter int LINK_REG = 31
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_valid,
   input  logic [NB_DATA-1:0] i_instruction,
   input  logic [NB_DATA-1:0] i_pc4,
   input  logic               i_hold,
   input  logic               i_wb_we,
   input  logic [NB_ADDR-1:0] i_wb_addr,
   input  logic [NB_DATA-1:0] i_wb_data,
   input  logic               i_ex_regwrite,
   input  logic               i_ex_memread,
   input  logic [NB_ADDR-1:0] i_ex_dst,
   input  logic               i_mem_regwrite,
   input  logic               i_mem_memread,
   input  logic [NB_ADDR-1:0] i_mem_dst,
   input  logic [NB_DATA-1:0] i_mem_result,
   output logic               o_stall,
   output logic               o_pc_sel,
   output logic [NB_DATA-1:0] o_pc_target,
   output logic               o_flush_if,
   output logic               o_valid,
   output logic [NB_ADDR-1:0] o_rs,
   output logic [NB_ADDR-1:0] o_rt,
   output logic [NB_ADDR-1:0] o_dst,
   output logic [NB_DATA-1:0] o_reg_da,
   output logic [NB_DATA-1:0] o_reg_db,
   output logic [NB_DATA-1:0] o_imm,
   output logic [NB_DATA-1:0] o_pc4,
   output logic [4:0]         o_shamt,
   output logic [5:0]         o_funct,
   output logic               o_regwrite,
   output logic               o_memread,
   output logic               o_memwrite,
   output logic               o_mem2reg,
   output logic               o_alusrc,
   output logic               o_sign,
   output logic               o_link,
   output logic [1:0]         o_width,
   output logic [1:0]         o_aluop
);
   localparam int NREGS = 2**NB_ADDR;
   localparam logic [NB_ADDR-1:0] LINK = NB_ADDR'(LINK_REG);

   localparam logic [5:0] OP_R    = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                          OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                          OP_SLTI = 6'h0a, OP_ANDI = 6'h0c, OP_ORI  = 6'h0d,
                          OP_XORI = 6'h0e, OP_LUI  = 6'h0f, OP_LB   = 6'h20,
                          OP_LH   = 6'h21, OP_LW   = 6'h23, OP_LBU  = 6'h24,
                          OP_LHU  = 6'h25, OP_SB   = 6'h28, OP_SH   = 6'h29,
                          OP_SW   = 6'h2b;
   localparam logic [5:0] FN_JR = 6'h08, FN_JALR = 6'h09;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       mem2reg;
      logic       alusrc;
      logic       sign;
      logic       link;
      logic [1:0] width;
      logic [1:0] aluop;
   } ctrl_t;

   typedef struct packed {
      logic               valid;
      logic [NB_ADDR-1:0] rs;
      logic [NB_ADDR-1:0] rt;
      logic [NB_ADDR-1:0] dst;
      logic [NB_DATA-1:0] da;
      logic [NB_DATA-1:0] db;
      logic [NB_DATA-1:0] imm;
      logic [NB_DATA-1:0] pc4;
      logic [4:0]         shamt;
      logic [5:0]         funct;
      ctrl_t              ctrl;
   } idex_t;

   logic [NB_DATA-1:0] rf [NREGS];
   logic [5:0]         opcode, funct;
   logic [NB_ADDR-1:0] rs, rt, rd, d_dst;
   logic [NB_DATA-1:0] imm_s, imm_z, d_imm, rs_val, rt_val, fwd_a, fwd_b, target;
   logic               reads_rt, is_br, is_jr, is_j;
   logic               mem_fwd_ok, rs_busy, rt_busy, load_use, br_haz, hazard, stall, taken;
   ctrl_t              d_ctrl;
   idex_t              d, q;

   assign opcode = i_instruction[31:26];
   assign funct  = i_instruction[5:0];
   assign rs     = i_instruction[21 +: NB_ADDR];
   assign rt     = i_instruction[16 +: NB_ADDR];
   assign rd     = i_instruction[11 +: NB_ADDR];
   assign imm_s  = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};
   assign imm_z  = {{(NB_DATA-16){1'b0}}, i_instruction[15:0]};

   // Register reads: r0 is hard zero, a same-cycle write-back is passed through
   assign rs_val = (rs == '0) ? '0 : (i_wb_we && i_wb_addr == rs) ? i_wb_data : rf[rs];
   assign rt_val = (rt == '0) ? '0 : (i_wb_we && i_wb_addr == rt) ? i_wb_data : rf[rt];

   // MEM ALU results are newer than the file; loads in MEM are not ready yet
   assign mem_fwd_ok = i_mem_regwrite && !i_mem_memread && (i_mem_dst != '0);
   assign fwd_a      = (mem_fwd_ok && i_mem_dst == rs) ? i_mem_result : rs_val;
   assign fwd_b      = (mem_fwd_ok && i_mem_dst == rt) ? i_mem_result : rt_val;

   // Register file write port, cleared on reset
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else if (i_wb_we && i_wb_addr != '0) begin
         rf[i_wb_addr] <= i_wb_data;
      end
   end

   // Control decode; unknown opcodes fall through as all-zero control
   always_comb begin
      d_ctrl   = '0;
      d_dst    = '0;
      d_imm    = imm_s;
      reads_rt = 1'b0;
      is_br    = 1'b0;
      is_jr    = 1'b0;
      is_j     = 1'b0;
      case (opcode)
         OP_R: begin
            is_jr           = (funct == FN_JR) || (funct == FN_JALR);
            reads_rt        = !is_jr;
            d_ctrl.regwrite = (funct != FN_JR);
            d_ctrl.link     = (funct == FN_JALR);
            d_ctrl.aluop    = 2'b10;
            d_ctrl.sign     = 1'b1;
            d_dst           = rd;
         end
         OP_J: begin
            is_j        = 1'b1;
            d_ctrl.sign = 1'b1;
         end
         OP_JAL: begin
            is_j            = 1'b1;
            d_ctrl.regwrite = 1'b1;
            d_ctrl.link     = 1'b1;
            d_ctrl.sign     = 1'b1;
            d_dst           = LINK;
         end
         OP_BEQ, OP_BNE: begin
            is_br       = 1'b1;
            reads_rt    = 1'b1;
            d_ctrl.sign = 1'b1;
         end
         OP_ADDI, OP_SLTI, OP_LUI, OP_ANDI, OP_ORI, OP_XORI: begin
            d_ctrl.regwrite = 1'b1;
            d_ctrl.alusrc   = 1'b1;
            d_ctrl.aluop    = 2'b11;
            d_ctrl.sign     = 1'b1;
            d_dst           = rt;
            if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) d_imm = imm_z;
         end
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
            d_ctrl.regwrite = 1'b1;
            d_ctrl.memread  = 1'b1;
            d_ctrl.mem2reg  = 1'b1;
            d_ctrl.alusrc   = 1'b1;
            d_ctrl.width    = opcode[1:0];   // 00 byte, 01 half, 11 word
            d_ctrl.sign     = !(opcode == OP_LBU || opcode == OP_LHU);
            d_dst           = rt;
         end
         OP_SB, OP_SH, OP_SW: begin
            reads_rt        = 1'b1;
            d_ctrl.memwrite = 1'b1;
            d_ctrl.alusrc   = 1'b1;
            d_ctrl.width    = opcode[1:0];
            d_ctrl.sign     = 1'b1;
         end
         default: ;
      endcase
   end

   // A compare/JR source is not yet available if EX will write it or MEM is loading it
   assign rs_busy  = (rs != '0) && ((i_ex_regwrite && i_ex_dst == rs) || (i_mem_memread && i_mem_dst == rs));
   assign rt_busy  = (rt != '0) && ((i_ex_regwrite && i_ex_dst == rt) || (i_mem_memread && i_mem_dst == rt));
   assign load_use = i_ex_memread && (i_ex_dst != '0) && (i_ex_dst == rs || (reads_rt && i_ex_dst == rt));
   assign br_haz   = (is_br && (rs_busy || rt_busy)) || (is_jr && rs_busy);
   assign hazard   = i_valid && (load_use || br_haz);
   assign stall    = hazard || i_hold;
   assign taken    = is_j || is_jr || (is_br && ((fwd_a == fwd_b) ^ (opcode == OP_BNE)));

   // Redirect target for whichever control-flow type sits in ID
   always_comb begin
      if (is_j)       target = {i_pc4[NB_DATA-1:28], i_instruction[25:0], 2'b00};
      else if (is_jr) target = fwd_a;
      else            target = i_pc4 + (imm_s << 2);
   end

   // Combinational outputs are gated by reset so nothing pends while it is low
   assign o_stall     = i_rst_n && stall;
   assign o_pc_sel    = i_rst_n && i_valid && !stall && taken;
   assign o_flush_if  = o_pc_sel;
   assign o_pc_target = i_rst_n ? target : '0;

   // Next ID/EX contents: a bubble unless a real, hazard-free instruction is present
   always_comb begin
      d = '0;
      if (i_valid && !hazard) begin
         d.valid = 1'b1;
         d.rs    = rs;
         d.rt    = rt;
         d.dst   = d_dst;
         d.da    = d_ctrl.link ? i_pc4 : rs_val;
         d.db    = rt_val;
         d.imm   = d_imm;
         d.pc4   = i_pc4;
         d.shamt = i_instruction[10:6];
         d.funct = funct;
         d.ctrl  = d_ctrl;
      end
   end

   // ID/EX register, frozen while downstream holds
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n)     q <= '0;
      else if (!i_hold) q <= d;
   end

   assign o_valid    = q.valid;
   assign o_rs       = q.rs;
   assign o_rt       = q.rt;
   assign o_dst      = q.dst;
   assign o_reg_da   = q.da;
   assign o_reg_db   = q.db;
   assign o_imm      = q.imm;
   assign o_pc4      = q.pc4;
   assign o_shamt    = q.shamt;
   assign o_funct    = q.funct;
   assign o_regwrite = q.ctrl.regwrite;
   assign o_memread  = q.ctrl.memread;
   assign o_memwrite = q.ctrl.memwrite;
   assign o_mem2reg  = q.ctrl.mem2reg;
   assign o_alusrc   = q.ctrl.alusrc;
   assign o_sign     = q.ctrl.sign;
   assign o_link     = q.ctrl.link;
   assign o_width    = q.ctrl.width;
   assign o_aluop    = q.ctrl.aluop;
endmodule
